// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NREQ requesters.
// Each accepted word goes out as an optional {HDR_TAG,id} header, then data LSB-byte first.
module uart_tx_arbiter #(
  parameter int DBIT      = 8,
  parameter int NBYTES    = 4,
  parameter int NREQ      = 2,
  parameter int NB_ID     = 3,
  parameter int HEADER_EN = 1,
  parameter logic [DBIT-NB_ID-1:0] HDR_TAG = 5'b10100
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [NREQ-1:0]             i_req_valid,
  input  logic [NREQ*NBYTES*DBIT-1:0] i_req_data,
  output logic [NREQ-1:0]             o_req_ready,
  output logic                        o_tx_start,
  output logic [DBIT-1:0]             o_tx_data,
  input  logic                        i_tx_done_tick,
  output logic                        o_busy,
  output logic [NB_ID-1:0]            o_grant_id,
  output logic                        o_frame_done
);

  localparam int WW   = NBYTES * DBIT;
  localparam int NCNT = NBYTES + HEADER_EN;
  localparam int CW   = $clog2(NCNT + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_START, S_WAIT} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [NB_ID-1:0] r_last_grant;
  logic [NB_ID-1:0] r_grant_id;
  logic [WW-1:0]    r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_hdr_pend;
  logic [DBIT-1:0]  r_tx_data;
  logic             r_frame_done;

  logic [WW-1:0]    w_word [NREQ];
  logic [NREQ-1:0]  w_above;
  logic [NREQ-1:0]  w_masked;
  logic [NREQ-1:0]  w_src;
  logic [NREQ-1:0]  w_onehot;
  logic [NB_ID-1:0] w_win;
  logic             w_any;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign w_word[gi]  = i_req_data[gi*WW +: WW];
      assign w_above[gi] = (NB_ID'(gi) > r_last_grant);
    end
  endgenerate

  // Requesters above the last grant take precedence; otherwise wrap to the lowest valid.
  assign w_masked = i_req_valid & w_above;
  assign w_any    = |i_req_valid;
  assign w_src    = (|w_masked) ? w_masked : i_req_valid;

  always_comb begin
    w_win = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_src[i]) w_win = NB_ID'(i);
    end
  end

  assign w_onehot = w_any ? (NREQ'(1) << w_win) : '0;

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_next = S_LOAD;
      S_LOAD:  w_state_next = S_START;
      S_START: w_state_next = S_WAIT;
      S_WAIT:  if (i_tx_done_tick) w_state_next = (r_cnt == CW'(1)) ? S_IDLE : S_LOAD;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = (r_state == S_IDLE) ? w_onehot : '0;
    o_tx_start  = (r_state == S_START);
    o_busy      = (r_state != S_IDLE);
  end

  // LOAD presents the next byte, so every start follows a done tick by two cycles.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_last_grant <= NB_ID'(NREQ - 1);
      r_grant_id   <= '0;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_hdr_pend   <= 1'b0;
      r_tx_data    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_shift      <= w_word[w_win];
            r_grant_id   <= w_win;
            r_last_grant <= w_win;
            r_cnt        <= CW'(NCNT);
            r_hdr_pend   <= (HEADER_EN != 0);
          end
        end
        S_LOAD: begin
          if (r_hdr_pend) begin
            r_tx_data  <= {HDR_TAG, r_grant_id};
            r_hdr_pend <= 1'b0;
          end else begin
            r_tx_data <= r_shift[DBIT-1:0];
            r_shift   <= r_shift >> DBIT;
          end
        end
        S_WAIT: begin
          if (i_tx_done_tick) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) r_frame_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_tx_data    = r_tx_data;
  assign o_grant_id   = r_grant_id;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: a queue-based model of the frame protocol is
// compared against the DUT every cycle, plus directed literal expectations.
module tb_uart_tx_arbiter;
  localparam int DBIT = 8, NBYTES = 4, NREQ = 2, NB_ID = 3, HEADER_EN = 1;
  localparam logic [4:0] TAG = 5'b10100;
  localparam int WW = NBYTES * DBIT;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      valid = '0;
  logic [NREQ*WW-1:0]   data = '0;
  logic [NREQ-1:0]      ready;
  logic                 start;
  logic [DBIT-1:0]      txd;
  logic                 tick = 1'b0;
  logic                 busy;
  logic [NB_ID-1:0]     gid;
  logic                 fd;

  uart_tx_arbiter #(.DBIT(DBIT), .NBYTES(NBYTES), .NREQ(NREQ), .NB_ID(NB_ID),
                    .HEADER_EN(HEADER_EN), .HDR_TAG(TAG)) dut (
    .i_clock(clk), .i_reset(rst), .i_req_valid(valid), .i_req_data(data),
    .o_req_ready(ready), .o_tx_start(start), .o_tx_data(txd), .i_tx_done_tick(tick),
    .o_busy(busy), .o_grant_id(gid), .o_frame_done(fd));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  // model state
  bit         m_busy = 0, m_waiting = 0, m_fd_next = 0;
  int         m_last = NREQ - 1, m_gid = 0, m_due = -1, m_tick_due = -1;
  logic [7:0] m_cur = 8'h00;
  logic [7:0] m_q[$];
  // logs and stimulus knobs
  logic [7:0] log_b[$];
  int         log_g[$];
  int         fd_seen = 0, ticks_seen = 0;
  bit         pend[NREQ];
  logic [WW-1:0] wd[NREQ];
  bit         hold_all = 0, spurious = 0, fixed1 = 1, long_once = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] v, input int last);
    int k;
    for (int i = 1; i <= NREQ; i++) begin
      k = (last + i) % NREQ;
      if (v[k]) return NREQ'(1) << k;
    end
    return '0;
  endfunction

  function automatic int pick_delay();
    if (long_once) begin
      long_once = 0;
      return 1000;
    end
    if (fixed1) return 1;
    return $urandom_range(1, 6);
  endfunction

  function automatic bit any_pend();
    for (int i = 0; i < NREQ; i++) if (pend[i]) return 1;
    return 0;
  endfunction

  function automatic int lg(input int i);
    return (log_g.size() > i) ? log_g[i] : -1;
  endfunction

  function automatic int lb(input int i);
    return (log_b.size() > i) ? int'(log_b[i]) : -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_waiting = 0; m_fd_next = 0; m_last = NREQ - 1; m_gid = 0;
    m_due = -1; m_tick_due = -1; m_cur = 8'h00; m_q.delete();
  endtask

  // One clock cycle: drive inputs at the falling edge, then check and advance the model.
  task automatic step(input bit do_rst);
    logic [NREQ-1:0] er;
    bit exp_start, exp_fd;
    int k;
    @(negedge clk);
    rst = do_rst;
    if (hold_all) for (int i = 0; i < NREQ; i++) pend[i] = 1;
    tick = 1'b0;
    if (m_tick_due > 0) begin
      m_tick_due--;
      if (m_tick_due == 0) begin
        tick = 1'b1;
        m_tick_due = -1;
      end
    end else if (spurious && !m_busy && $urandom_range(0, 5) == 0) begin
      tick = 1'b1;
    end
    for (int i = 0; i < NREQ; i++) begin
      valid[i] = pend[i] && !do_rst;
      data[i*WW +: WW] = wd[i];
    end
    #1;
    if (m_due > 0) m_due--;
    exp_start = (m_due == 0);
    if (exp_start) m_due = -1;
    exp_fd = m_fd_next;
    m_fd_next = 0;
    er = m_busy ? '0 : rr_pick(valid, m_last);
    chk("ready", ready, er);
    chk("busy", busy, m_busy);
    chk("tx_start", start, exp_start);
    chk("frame_done", fd, exp_fd);
    chk("grant_id", gid, m_gid);
    if (fd) fd_seen++;
    if (exp_start) begin
      m_cur = (m_q.size() > 0) ? m_q.pop_front() : 8'h00;
      chk("tx_data", txd, m_cur);
      log_b.push_back(txd);
      m_waiting = 1;
      m_tick_due = pick_delay();
    end else if (m_waiting) begin
      chk("tx_data_hold", txd, m_cur);
    end
    if (do_rst) begin
      model_reset();
    end else begin
      if (m_waiting && tick) begin
        ticks_seen++;
        m_waiting = 0;
        if (m_q.size() == 0) begin
          m_fd_next = 1;
          m_busy = 0;
        end else begin
          m_due = 2;
        end
      end
      if (er != '0) begin
        k = 0;
        for (int i = 0; i < NREQ; i++) if (er[i]) k = i;
        m_busy = 1; m_last = k; m_gid = k;
        if (HEADER_EN != 0) m_q.push_back({TAG, NB_ID'(k)});
        for (int b = 0; b < NBYTES; b++) m_q.push_back(wd[k][b*8 +: 8]);
        m_due = 2;
        pend[k] = 0;
        log_g.push_back(k);
      end
    end
  endtask

  task automatic drain(input int lim);
    int n;
    n = 0;
    while ((m_busy || any_pend()) && n < lim) begin
      step(0);
      n++;
    end
    chk("drain_in_budget", (n < lim), 1);
    step(0);
  endtask

  task automatic clear_logs();
    log_b.delete(); log_g.delete(); fd_seen = 0; ticks_seen = 0;
  endtask

  initial begin
    int n;
    bit re;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 0;
      wd[i] = '0;
    end
    repeat (3) step(1);
    // reset state
    chk("rst_ready", ready, 0);
    chk("rst_start", start, 0);
    chk("rst_txd", txd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gid", gid, 0);
    chk("rst_fd", fd, 0);

    // single word with header
    clear_logs();
    fixed1 = 1;
    pend[0] = 1; wd[0] = 32'hDEADBEEF;
    drain(200);
    chk("single_nbytes", log_b.size(), 5);
    chk("single_b0", lb(0), 8'hA0);
    chk("single_b1", lb(1), 8'hEF);
    chk("single_b2", lb(2), 8'hBE);
    chk("single_b3", lb(3), 8'hAD);
    chk("single_b4", lb(4), 8'hDE);
    chk("single_fd_count", fd_seen, 1);
    chk("single_grant", lg(0), 0);

    // contention from reset, req0 re-asserted during req1's frame
    step(1); step(1);
    clear_logs();
    pend[0] = 1; wd[0] = 32'h11223344;
    pend[1] = 1; wd[1] = 32'h55667788;
    n = 0; re = 0;
    while ((m_busy || any_pend()) && n < 400) begin
      step(0);
      n++;
      if (log_g.size() == 2 && m_busy && !re) begin
        pend[0] = 1; wd[0] = 32'hCAFEF00D;
        re = 1;
      end
    end
    chk("cont_in_budget", (n < 400), 1);
    step(0);
    chk("cont_g0", lg(0), 0);
    chk("cont_g1", lg(1), 1);
    chk("cont_g2", lg(2), 0);
    chk("cont_hdr0", lb(0), 8'hA0);
    chk("cont_hdr1", lb(5), 8'hA1);
    chk("cont_req1_b0", lb(6), 8'h88);
    chk("cont_req0_again_b0", lb(11), 8'h0D);

    // fairness: both valids held for four frames
    step(1);
    clear_logs();
    hold_all = 1;
    n = 0;
    while (log_g.size() < 4 && n < 400) begin
      step(0);
      n++;
    end
    hold_all = 0;
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    drain(400);
    chk("fair_g0", lg(0), 0);
    chk("fair_g1", lg(1), 1);
    chk("fair_g2", lg(2), 0);
    chk("fair_g3", lg(3), 1);
    chk("fair_fd_count", fd_seen, 4);

    // one 1000-cycle done tick among 1-cycle ones
    clear_logs();
    long_once = 1;
    pend[1] = 1; wd[1] = 32'h0BADBEEF;
    drain(2000);
    chk("long_nbytes", log_b.size(), 5);
    chk("long_hdr", lb(0), 8'hA1);

    // reset after the second done tick of a frame
    step(1);
    clear_logs();
    pend[0] = 1; wd[0] = 32'h87654321;
    n = 0;
    while (ticks_seen < 2 && n < 100) begin
      step(0);
      n++;
    end
    chk("midrst_ticks", ticks_seen, 2);
    pend[0] = 0;
    step(1);
    step(0);
    chk("midrst_ready", ready, 0);
    chk("midrst_start", start, 0);
    chk("midrst_txd", txd, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_gid", gid, 0);
    chk("midrst_fd", fd, 0);
    clear_logs();
    pend[1] = 1; wd[1] = 32'h00C0FFEE;
    step(0);
    chk("midrst_req1_ready", ready, 2'b10);
    drain(200);
    chk("midrst_req1_hdr", lb(0), 8'hA1);
    chk("midrst_req1_b0", lb(1), 8'hEE);

    // randomized traffic with random done-tick spacing and ignored stray ticks
    fixed1 = 0;
    spurious = 1;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1;
          wd[i] = $urandom;
        end else if (pend[i] && m_busy && $urandom_range(0, 15) == 0) begin
          pend[i] = 0;
        end
      end
      step(0);
    end
    spurious = 0;
    drain(5000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
